acq_sequencer: RTL and testbench
================================

// Module: acq_sequencer
// PURPOSE
//  Sequences one CCD acquisition from MCU request to FIFO drain. Sits between ilx511b/ad7621
//  and fifo_ccd: arms on request, gates ADC samples into the FIFO for exactly one frame,
//  raises pixel_ready for the MCU, and re-arms once the FIFO is drained.
//  Takes over the free-running pixel_ready latch and the ungated FIFO write path.
// PARAMETERS
//  FRAME_PIX    1024     pixels written to the FIFO per acquisition
//  CNT_W        11       pixel counter width; must hold FRAME_PIX
//  TIMEOUT_CYC  2000000  sys_clk cycles in ARM without frame start before abort
// PORTS
//  sys_clk          in   1      acquisition clock (sys_2xclk domain)
//  sys_rst          in   1      asynchronous, active-high reset
//  acq_req          in   1      MCU request level (fifo_rset | trigger); rising edge is a request
//  frame_start      in   1      1-cycle pulse from ilx511b at start of a CCD readout (flag_adc_restart)
//  pix_valid        in   1      1-cycle pulse per ADC sample (ad7621_flag_fifo_do)
//  fifo_full        in   1      fifo_ccd full
//  fifo_empty       in   1      fifo_ccd empty
//  fifo_wr_en       out  1      gated FIFO write enable
//  fifo_clr         out  1      1-cycle FIFO flush pulse
//  pixel_ready      out  1      frame complete in FIFO; MCU may read
//  busy             out  1      high in any state except IDLE
//  state_o          out  2      current state encoding
//  pix_cnt          out  CNT_W  pixels accepted in current frame
//  err_ovf          out  1      sticky: sample dropped because FIFO was full
//  err_short        out  1      sticky: frame_start arrived before FRAME_PIX pixels
//  err_tmo          out  1      sticky: ARM timed out
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending request cleared, counters 0.
//  Request detect: registered edge detector on acq_req; req_pulse one cycle after the 0->1 sample.
//  States: IDLE=0, ARM=1, CAPTURE=2, READY=3.
//   IDLE:    req_pulse or pending -> ARM; fifo_clr=1 for that one cycle; pending cleared; pix_cnt<=0.
//   ARM:     frame_start -> CAPTURE; timeout counter reaching TIMEOUT_CYC-1 -> IDLE and err_tmo<=1.
//            Timeout counter cleared on ARM entry.
//   CAPTURE: fifo_wr_en = pix_valid & ~fifo_full (combinational, same cycle).
//            Each pix_valid increments pix_cnt, even when dropped.
//            pix_valid & fifo_full -> err_ovf<=1.
//            pix_cnt reaching FRAME_PIX (the increment to FRAME_PIX) -> READY next cycle.
//            frame_start with pix_cnt<FRAME_PIX -> err_short<=1, READY.
//            frame_start wins over the pixel completing on the same cycle: that pixel is
//            written, then READY.
//   READY:   pixel_ready=1 (registered, asserted on the first READY cycle); fifo_wr_en=0.
//            fifo_empty high -> IDLE; pixel_ready drops on the IDLE cycle.
//  fifo_wr_en is 0 outside CAPTURE. Samples in IDLE, ARM or READY are discarded silently.
//  Request in ARM, CAPTURE or READY sets pending (1 deep; extra requests are lost).
//  A pending request starts a new ARM on the first IDLE cycle.
//  Request in ARM does not restart ARM.
//  Sticky errors clear only on sys_rst or on ARM entry.
//  sys_rst mid-frame: immediate IDLE, outputs 0. The FIFO is flushed by its own reset.
//  pix_cnt saturates at FRAME_PIX, never wraps.
// TESTING
//  T1 rise acq_req; frame_start after 10 cyc; 1024 pix_valid, FIFO never full
//     -> fifo_clr 1 cyc, 1024 fifo_wr_en, pixel_ready=1, drain to empty -> pixel_ready=0, IDLE.
//  T2 as T1, fifo_full forced high for pixels 500..509
//     -> 1014 writes, err_ovf=1, pix_cnt=1024, READY reached.
//  T3 request, no frame_start, TIMEOUT_CYC=100
//     -> back to IDLE after 100 ARM cycles, err_tmo=1, pixel_ready stays 0.
//  T4 frame_start again after 600 pixels -> err_short=1, READY with pix_cnt=600.
//  T5 second acq_req edge during CAPTURE
//     -> after drain, IDLE for 1 cycle then ARM with fifo_clr; third edge in CAPTURE lost.
//  T6 assert sys_rst at pixel 300 of CAPTURE -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : acq_sequencer
// Brief    : Arms on an MCU request, gates one CCD frame of ADC samples into
//            fifo_ccd, flags pixel_ready and re-arms once the FIFO drains.
// Revision : 1.0 - initial release
// ============================================================================
module acq_sequencer #(
    parameter int FRAME_PIX   = 1024,
    parameter int CNT_W       = 11,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             acq_req,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             fifo_wr_en,
    output logic             fifo_clr,
    output logic             pixel_ready,
    output logic             busy,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] pix_cnt,
    output logic             err_ovf,
    output logic             err_short,
    output logic             err_tmo
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] C_FRAME      = CNT_W'(FRAME_PIX);
    localparam logic [CNT_W-1:0] C_FRAME_LAST = CNT_W'(FRAME_PIX - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CAPTURE = 2'd2,
        S_READY   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_req_d;
    logic               r_req_pulse;
    logic               r_pending;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               w_arm_entry;
    logic               w_cnt_inc;
    logic               w_set_ovf;
    logic               w_set_short;
    logic               w_set_tmo;

    always_comb begin
        w_state_nxt = r_state;
        fifo_clr    = 1'b0;
        fifo_wr_en  = 1'b0;
        w_arm_entry = 1'b0;
        w_cnt_inc   = 1'b0;
        w_set_ovf   = 1'b0;
        w_set_short = 1'b0;
        w_set_tmo   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_req_pulse || r_pending) begin
                    w_state_nxt = S_ARM;
                    fifo_clr    = 1'b1;
                    w_arm_entry = 1'b1;
                end
            end
            S_ARM: begin
                if (frame_start) begin
                    w_state_nxt = S_CAPTURE;
                end else if (r_tmo_cnt == C_TMO_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_set_tmo   = 1'b1;
                end
            end
            S_CAPTURE: begin
                fifo_wr_en = pix_valid & ~fifo_full;
                w_set_ovf  = pix_valid & fifo_full;
                w_cnt_inc  = pix_valid && (pix_cnt != C_FRAME);
                // An early frame_start ends the frame even if this cycle's pixel completes it.
                if (frame_start && (pix_cnt < C_FRAME)) begin
                    w_set_short = 1'b1;
                    w_state_nxt = S_READY;
                end else if (pix_valid && (pix_cnt == C_FRAME_LAST)) begin
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (fifo_empty) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_req_d     <= 1'b0;
            r_req_pulse <= 1'b0;
            r_pending   <= 1'b0;
            r_tmo_cnt   <= '0;
            pix_cnt     <= '0;
            pixel_ready <= 1'b0;
            err_ovf     <= 1'b0;
            err_short   <= 1'b0;
            err_tmo     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_d     <= acq_req;
            r_req_pulse <= acq_req & ~r_req_d;
            pixel_ready <= (w_state_nxt == S_READY);

            // One-deep request memory for requests arriving while a frame is in flight.
            if (w_arm_entry) begin
                r_pending <= 1'b0;
            end else if (r_req_pulse && (r_state != S_IDLE)) begin
                r_pending <= 1'b1;
            end

            if (w_arm_entry) begin
                r_tmo_cnt <= '0;
            end else if ((r_state == S_ARM) && (w_state_nxt == S_ARM)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if (w_arm_entry) begin
                pix_cnt <= '0;
            end else if (w_cnt_inc) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            if (w_arm_entry) begin
                err_ovf   <= 1'b0;
                err_short <= 1'b0;
                err_tmo   <= 1'b0;
            end else begin
                if (w_set_ovf)   err_ovf   <= 1'b1;
                if (w_set_short) err_short <= 1'b1;
                if (w_set_tmo)   err_tmo   <= 1'b1;
            end
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_acq_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_acq_sequencer
// Brief    : Vector table, directed frame scenarios and randomized traffic
//            checked against a behavioural model of acq_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acq_sequencer;

    localparam int FRAME_PIX   = 1024;
    localparam int CNT_W       = 11;
    localparam int TIMEOUT_CYC = 100;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             acq_req = 1'b0;
    logic             frame_start = 1'b0;
    logic             pix_valid = 1'b0;
    logic             fifo_full = 1'b0;
    logic             fifo_empty = 1'b0;
    logic             fifo_wr_en, fifo_clr, pixel_ready, busy;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] pix_cnt;
    logic             err_ovf, err_short, err_tmo;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_clr   = 0;

    always #5 sys_clk = ~sys_clk;

    acq_sequencer #(
        .FRAME_PIX   (FRAME_PIX),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .acq_req     (acq_req),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_clr    (fifo_clr),
        .pixel_ready (pixel_ready),
        .busy        (busy),
        .state_o     (state_o),
        .pix_cnt     (pix_cnt),
        .err_ovf     (err_ovf),
        .err_short   (err_short),
        .err_tmo     (err_tmo)
    );

    typedef struct {
        int req, fs, pv, full, empty;
        int st, wr, clr, rdy, cnt, ovf, shrt, tmo;
    } vec_t;

    function automatic logic [19:0] dut_outs();
        return {state_o, fifo_wr_en, fifo_clr, pixel_ready, busy, pix_cnt,
                err_ovf, err_short, err_tmo};
    endfunction

    function automatic logic [19:0] pack(int st, int wr, int clr, int rdy, int cnt,
                                         int ovf, int shrt, int tmo);
        return {2'(st), wr != 0, clr != 0, rdy != 0, st != 0, CNT_W'(cnt),
                ovf != 0, shrt != 0, tmo != 0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs on the falling edge and tally strobes just after.
    task automatic cyc(input logic req, input logic fs, input logic pv,
                       input logic full, input logic empty);
        @(negedge sys_clk);
        acq_req     = req;
        frame_start = fs;
        pix_valid   = pv;
        fifo_full   = full;
        fifo_empty  = empty;
        #1;
        if (fifo_wr_en) n_wr++;
        if (fifo_clr)   n_clr++;
    endtask

    task automatic reset_dut();
        @(negedge sys_clk);
        sys_rst = 1'b1;
        acq_req = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
        fifo_full = 1'b0; fifo_empty = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        n_wr  = 0;
        n_clr = 0;
    endtask

    // Request, 10 idle ARM cycles, then frame_start; CAPTURE begins after this.
    task automatic start_acq();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
    endtask

    task automatic pixels(input int n, input int flo, input int fhi,
                          input int r1, input int r2);
        for (int i = 0; i < n; i++) begin
            cyc(((i >= r1) && (i < r1 + 5)) || ((i >= r2) && (i < r2 + 5)),
                0, 1, (i >= flo) && (i <= fhi), 0);
        end
    endtask

    // Behavioural reference: phase, counters and flags updated from the rules
    int m_ph, m_cnt, m_tmo, m_pend, m_pulse, m_req_d, m_rdy, m_ovf, m_shrt, m_etmo;

    task automatic model_reset();
        m_ph = 0; m_cnt = 0; m_tmo = 0; m_pend = 0; m_pulse = 0; m_req_d = 0;
        m_rdy = 0; m_ovf = 0; m_shrt = 0; m_etmo = 0;
    endtask

    task automatic model_step(input int req, input int fs, input int pv,
                              input int full, input int empty);
        int nph;
        int new_pulse;
        int exp_wr;
        int exp_clr;
        exp_wr  = (m_ph == 2 && pv != 0 && full == 0) ? 1 : 0;
        exp_clr = (m_ph == 0 && (m_pulse != 0 || m_pend != 0)) ? 1 : 0;
        chk("random", {12'h0, dut_outs()},
            {12'h0, pack(m_ph, exp_wr, exp_clr, m_rdy, m_cnt, m_ovf, m_shrt, m_etmo)});
        new_pulse = (req != 0 && m_req_d == 0) ? 1 : 0;
        m_req_d   = req;
        nph       = m_ph;
        if (m_ph != 0 && m_pulse != 0) m_pend = 1;
        if (m_ph == 0) begin
            if (m_pulse != 0 || m_pend != 0) begin
                nph = 1; m_pend = 0; m_cnt = 0; m_tmo = 0;
                m_ovf = 0; m_shrt = 0; m_etmo = 0;
            end
        end else if (m_ph == 1) begin
            if (fs != 0) nph = 2;
            else if (m_tmo == TIMEOUT_CYC - 1) begin nph = 0; m_etmo = 1; end
            else m_tmo++;
        end else if (m_ph == 2) begin
            if (fs != 0 && m_cnt < FRAME_PIX) begin
                m_shrt = 1;
                nph = 3;
            end else if (pv != 0 && m_cnt == FRAME_PIX - 1) begin
                nph = 3;
            end
            if (pv != 0) begin
                if (full != 0) m_ovf = 1;
                if (m_cnt < FRAME_PIX) m_cnt++;
            end
        end else begin
            if (empty != 0) nph = 0;
        end
        m_ph    = nph;
        m_rdy   = (nph == 3) ? 1 : 0;
        m_pulse = new_pulse;
    endtask

    vec_t vecs[13];

    initial begin
        int n_arm;
        int n_rdy;
        int rq;
        int fs;
        int pv;
        int fl;
        int em;

        vecs[0]  = '{1,0,0,0,0, 0,0,0,0,0,0,0,0};
        vecs[1]  = '{1,0,1,0,0, 0,0,1,0,0,0,0,0};
        vecs[2]  = '{0,0,1,0,0, 1,0,0,0,0,0,0,0};
        vecs[3]  = '{0,1,0,0,0, 1,0,0,0,0,0,0,0};
        vecs[4]  = '{0,0,1,0,0, 2,1,0,0,0,0,0,0};
        vecs[5]  = '{0,0,1,1,0, 2,0,0,0,1,0,0,0};
        vecs[6]  = '{0,0,0,0,0, 2,0,0,0,2,1,0,0};
        vecs[7]  = '{1,0,1,0,0, 2,1,0,0,2,1,0,0};
        vecs[8]  = '{1,1,1,0,0, 2,1,0,0,3,1,0,0};
        vecs[9]  = '{0,0,1,0,0, 3,0,0,1,4,1,1,0};
        vecs[10] = '{0,0,0,0,1, 3,0,0,1,4,1,1,0};
        vecs[11] = '{0,0,0,0,0, 0,0,1,0,4,1,1,0};
        vecs[12] = '{0,0,0,0,0, 1,0,0,0,0,0,0,0};

        reset_dut();
        chk("reset_state", {12'h0, dut_outs()}, 32'h0);
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].req != 0, vecs[i].fs != 0, vecs[i].pv != 0,
                vecs[i].full != 0, vecs[i].empty != 0);
            chk($sformatf("vec%0d", i), {12'h0, dut_outs()},
                {12'h0, pack(vecs[i].st, vecs[i].wr, vecs[i].clr, vecs[i].rdy,
                             vecs[i].cnt, vecs[i].ovf, vecs[i].shrt, vecs[i].tmo)});
        end

        // Full clean frame
        reset_dut();
        start_acq();
        pixels(FRAME_PIX, -1, -2, -100, -100);
        cyc(0, 0, 0, 0, 0);
        chk("t1_ready", {12'h0, dut_outs()}, {12'h0, pack(3, 0, 0, 1, FRAME_PIX, 0, 0, 0)});
        chk("t1_writes", n_wr, FRAME_PIX);
        chk("t1_clr", n_clr, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t1_drained", {state_o, pixel_ready}, 3'b000);

        // FIFO full for pixels 500..509
        reset_dut();
        start_acq();
        pixels(FRAME_PIX, 500, 509, -100, -100);
        cyc(0, 0, 0, 0, 0);
        chk("t2_writes", n_wr, FRAME_PIX - 10);
        chk("t2_state", {12'h0, dut_outs()}, {12'h0, pack(3, 0, 0, 1, FRAME_PIX, 1, 0, 0)});

        // ARM timeout
        reset_dut();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("t3_clr", n_clr, 1);
        n_arm = 0;
        n_rdy = 0;
        for (int k = 0; k < 300; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (state_o == 2'd1) n_arm++;
            if (pixel_ready) n_rdy++;
            if (state_o == 2'd0) break;
        end
        chk("t3_arm_cycles", n_arm, TIMEOUT_CYC);
        chk("t3_end", {state_o, err_tmo, pixel_ready}, 4'b0010);
        chk("t3_no_ready", n_rdy, 0);

        // Early frame_start after 600 pixels
        reset_dut();
        start_acq();
        pixels(600, -1, -2, -100, -100);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t4_short", {12'h0, dut_outs()}, {12'h0, pack(3, 0, 0, 1, 600, 0, 1, 0)});

        // Two request edges during CAPTURE: one re-arm, the second edge is lost
        reset_dut();
        start_acq();
        pixels(FRAME_PIX, -1, -2, 100, 200);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t5_idle_clr", {state_o, fifo_clr}, 3'b001);
        cyc(0, 0, 0, 0, 0);
        chk("t5_rearm", {state_o, fifo_clr}, 3'b010);
        for (int k = 0; k < 300; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (state_o == 2'd0) break;
        end
        n_clr = 0;
        repeat (5) cyc(0, 0, 0, 0, 0);
        chk("t5_no_third", {30'h0, state_o}, 32'h0);
        chk("t5_no_clr", n_clr, 0);

        // Asynchronous reset mid-frame
        reset_dut();
        start_acq();
        pixels(300, -1, -2, -100, -100);
        @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("t6_async_rst", {12'h0, dut_outs()}, 32'h0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        chk("t6_after", {state_o, fifo_clr, fifo_wr_en}, 4'b0000);

        // Randomized traffic against the reference model
        reset_dut();
        model_reset();
        rq = 0;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 99) < 3) rq = 1 - rq;
            fs = ($urandom_range(0, 999) < ((m_ph == 2) ? 1 : 40)) ? 1 : 0;
            pv = ($urandom_range(0, 3) != 0) ? 1 : 0;
            fl = ($urandom_range(0, 9) == 0) ? 1 : 0;
            em = ($urandom_range(0, 19) == 0) ? 1 : 0;
            @(negedge sys_clk);
            acq_req     = (rq != 0);
            frame_start = (fs != 0);
            pix_valid   = (pv != 0);
            fifo_full   = (fl != 0);
            fifo_empty  = (em != 0);
            #1;
            model_step(rq, fs, pv, fl, em);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
